// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and bit-period helper shared with the transmit side
package uart_pkg;
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;
  localparam logic [2:0] PARITY    = 3'd5;
  function automatic int clks_per_bit(input int clk_mhz, input int baud);
    return clk_mhz * 1000000 / baud;
  endfunction
endpackage

// File: rtl/fifo.sv
// fifo: first-word fall-through buffer; a write into a full fifo without a read is dropped and flagged
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic             full,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic wr_ok, rd_ok;
  assign valid = count != '0;
  assign full = count == CW'(DEPTH);
  assign rd_ok = rd_en & valid;
  assign wr_ok = wr_en & (~full | rd_ok);
  assign drop = wr_en & full & ~rd_ok;
  assign rd_data = valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: synchronizer, framing FSM and shift register; pulses push for one cycle per good byte (UART_RX_PARITY_EN adds even parity)
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       push,
  output logic       frame_err_set
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err_set
`endif
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  logic s1, s2, armed, par_ok;
  logic [1:0] ready;
  logic [2:0] state, bit_idx;
  logic [CW-1:0] cnt;
  logic [7:0] shreg;
  logic done_half, done_bit;
  assign done_half = cnt == CW'(HALF - 1);
  assign done_bit = cnt == CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_ok = ~^{shreg, par_bit};
`else
  assign par_ok = 1'b1;
`endif
  // armed only after the synchronizer holds a real line sample that was high
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      ready <= '0;
      armed <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      data <= '0;
      push <= 1'b0;
      frame_err_set <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
      parity_err_set <= 1'b0;
`endif
    end else begin
      s1 <= rx;
      s2 <= s1;
      ready <= {ready[0], 1'b1};
      armed <= armed | (ready[1] & s2);
      push <= 1'b0;
      frame_err_set <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_set <= 1'b0;
`endif
      cnt <= cnt + CW'(1);
      case (state)
        IDLE: begin
          cnt <= '0;
          bit_idx <= '0;
          if (armed && !s2) state <= START;
        end
        START: if (done_half) begin
          cnt <= '0;
          state <= s2 ? IDLE : DATA;
        end
        DATA: if (done_bit) begin
          cnt <= '0;
          shreg <= {s2, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= PARITY;
`else
          if (bit_idx == 3'd7) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (done_bit) begin
          cnt <= '0;
          par_bit <= s2;
          state <= STOP;
        end
`endif
        STOP: if (done_bit) begin
          cnt <= '0;
          state <= s2 ? IDLE : WAIT_IDLE;
          frame_err_set <= ~s2;
          push <= s2 & par_ok;
          data <= shreg;
`ifdef UART_RX_PARITY_EN
          parity_err_set <= s2 & ~par_ok;
`endif
        end
        WAIT_IDLE: begin
          cnt <= '0;
          if (s2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_with_fifo.sv
// uart_rx_with_fifo: UART receiver feeding a FWFT fifo with sticky error flags (UART_RX_PARITY_EN adds parity_err)
module uart_rx_with_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_RATE   = 115200,
  parameter int CLK_VAL_MHZ = 50,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_rd_en,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);
  logic [7:0] rx_byte;
  logic rx_push, ferr_set, drop;
`ifdef UART_RX_PARITY_EN
  logic perr_set;
`endif
  uart_rx #(.CLKS_PER_BIT(clks_per_bit(CLK_VAL_MHZ, BAUD_RATE))) u_rx (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data(rx_byte),
    .push(rx_push),
    .frame_err_set(ferr_set)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err_set(perr_set)
`endif
  );
  fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(rx_push),
    .wr_data(rx_byte),
    .rd_en(rx_rd_en),
    .rd_data(rx_data),
    .valid(rx_valid),
    .full(rx_full),
    .drop(drop)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= ferr_set | (frame_err & ~err_clr);
      overrun <= drop | (overrun & ~err_clr);
`ifdef UART_RX_PARITY_EN
      parity_err <= perr_set | (parity_err & ~err_clr);
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx_with_fifo.sv
// tb_uart_rx_with_fifo: directed and random frames checked against a byte-queue model of the receiver
module tb_uart_rx_with_fifo;
  localparam int DEPTH = 4;
  localparam int CPB = 8;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rx_rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, rx_full, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif
  always #5 clk = ~clk;
  uart_rx_with_fifo #(.BAUD_RATE(125000), .CLK_VAL_MHZ(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_rd_en(rx_rd_en),
    .rx_full(rx_full),
    .frame_err(frame_err),
    .overrun(overrun),
    .err_clr(err_clr)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );
  logic [7:0] q[$];
  bit m_ferr, m_ovr, settled;
  int checks, failures;
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model is only meaningful while no frame is in flight
  always @(posedge clk) begin
    #1;
    if (settled) begin
      check("valid", 8'(rx_valid), 8'(q.size() != 0));
      check("full", 8'(rx_full), 8'(q.size() == DEPTH));
      check("frame_err", 8'(frame_err), 8'(m_ferr));
      check("overrun", 8'(overrun), 8'(m_ovr));
      if (q.size() != 0) check("data", rx_data, q[0]);
    end
  end
  task automatic send_frame(input logic [7:0] b, input logic stop);
    settled = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^b;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    if (!stop) m_ferr = 1'b1;
    else if (q.size() == DEPTH) m_ovr = 1'b1;
    else q.push_back(b);
    settled = 1'b1;
  endtask
  task automatic pop();
    @(negedge clk);
    rx_rd_en = 1'b1;
    @(posedge clk);
    if (q.size() != 0) void'(q.pop_front());
    @(negedge clk);
    rx_rd_en = 1'b0;
  endtask
  task automatic pop_expect(input logic [7:0] exp);
    @(negedge clk);
    check("pop_data", rx_data, exp);
    pop();
  endtask
  task automatic clear_errs();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
  endtask
  task automatic glitch();
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (14) @(negedge clk);
  endtask
  task automatic do_reset();
    settled = 1'b0;
    rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 8'(rx_valid), 8'd0);
    check("rst_full", 8'(rx_full), 8'd0);
    check("rst_data", rx_data, 8'h00);
    check("rst_ferr", 8'(frame_err), 8'd0);
    check("rst_ovr", 8'(overrun), 8'd0);
    q.delete();
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    settled = 1'b1;
  endtask
  task automatic abort_frame(input logic [7:0] b);
    settled = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[4];
    repeat (4) @(negedge clk);
    do_reset();
  endtask
  task automatic send_with_pop(input logic [7:0] b);
    fork
      send_frame(b, 1'b1);
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
          @(negedge clk);
          seen = dut.rx_push;
        end
        check("push_seen", 8'(seen), 8'd1);
        if (seen) begin
          rx_rd_en = 1'b1;
          @(posedge clk);
          void'(q.pop_front());
          @(negedge clk);
          rx_rd_en = 1'b0;
        end
      end
    join
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    do_reset();
    send_frame(8'hA5, 1'b1);
    check("a5_valid", 8'(rx_valid), 8'd1);
    check("a5_data", rx_data, 8'hA5);
    pop();
    check("a5_popped", 8'(rx_valid), 8'd0);
    glitch();
    check("glitch_valid", 8'(rx_valid), 8'd0);
    check("glitch_ferr", 8'(frame_err), 8'd0);
    check("glitch_ovr", 8'(overrun), 8'd0);
    send_frame(8'h3C, 1'b0);
    check("bad_stop_ferr", 8'(frame_err), 8'd1);
    check("bad_stop_empty", 8'(rx_valid), 8'd0);
    send_frame(8'h11, 1'b1);
    check("after_ferr_data", rx_data, 8'h11);
    pop();
    clear_errs();
    check("ferr_cleared", 8'(frame_err), 8'd0);
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    check("five_full", 8'(rx_full), 8'd1);
    check("five_ovr", 8'(overrun), 8'd1);
    for (int i = 1; i <= 4; i++) pop_expect(8'(i));
    check("five_drained", 8'(rx_valid), 8'd0);
    clear_errs();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    send_with_pop(8'h06);
    check("pp_full", 8'(rx_full), 8'd1);
    check("pp_ovr", 8'(overrun), 8'd0);
    pop_expect(8'h02);
    pop_expect(8'h03);
    pop_expect(8'h04);
    pop_expect(8'h06);
    send_frame(8'h5A, 1'b1);
    abort_frame(8'hF0);
    repeat (100) @(negedge clk);
    check("abort_empty", 8'(rx_valid), 8'd0);
    repeat (40) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: send_frame(8'($urandom), $urandom_range(0, 7) != 0);
        6, 7: pop();
        8: clear_errs();
        default: glitch();
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    while (q.size() != 0) pop();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_with_fifo.md
UART_RX_WITH_FIFO -- requirements
Module: uart_rx_with_fifo

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-002 SHALL have parameter CLK_VAL_MHZ, default 50, clk frequency in MHz.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, receive buffer entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data  output  8  FIFO head byte, valid while rx_valid=1.
REQ-008 SHALL have port rx_valid  output  1  FIFO not empty.
REQ-009 SHALL have port rx_rd_en  input  1  pop FIFO head this cycle.
REQ-010 SHALL have port rx_full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 SHALL have port frame_err  output  1  sticky; a stop bit was sampled low.
REQ-012 SHALL have port overrun  output  1  sticky; a byte was dropped because the FIFO was full.
REQ-013 SHALL have port err_clr  input  1  clears frame_err and overrun.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-015 SHALL compute CLKS_PER_BIT = CLK_VAL_MHZ*1000000/BAUD_RATE (integer division) and HALF = CLKS_PER_BIT/2.
REQ-016 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-017 IDLE: a synchronized low moves to START, with the bit counter cleared.
REQ-018 START: after HALF clocks, resample; low moves to DATA; high (glitch) returns to IDLE with nothing pushed.
REQ-019 DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first, into a shift register; move to STOP after bit 7.
REQ-020 STOP: after CLKS_PER_BIT clocks, sample.
REQ-021 STOP high: push the byte to the FIFO on the next clock and go to IDLE.
REQ-022 STOP low: discard the byte, set frame_err and go to WAIT_IDLE.
REQ-023 WAIT_IDLE: stay until the synchronized line is high, then go to IDLE.
REQ-024 FIFO SHALL be first-word fall-through: rx_valid and rx_data update the cycle after a push into an empty FIFO.
REQ-025 rx_rd_en while rx_valid=0 SHALL be ignored; pointers and count unchanged.
REQ-026 A push while full, with no pop in the same cycle, SHALL drop the byte, set overrun and leave the FIFO contents intact.
REQ-027 A push and a pop in the same cycle SHALL both take effect, including when full; count unchanged, no overrun.
REQ-028 Read/write pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-029 If a sticky flag is set and err_clr is high in the same cycle, set SHALL win.
REQ-030 Sampling counters SHALL restart on every state entry; the receiver SHALL continue regardless of FIFO state.

Reset
REQ-031 On rst: state IDLE, synchronizer flops 1, counters 0, FIFO empty.
REQ-032 On rst: rx_valid=0, rx_full=0, rx_data=0, frame_err=0, overrun=0.
REQ-033 Reset mid-frame SHALL abandon the partial byte; it is never pushed.
REQ-034 After reset, a line held low SHALL start a frame only on a fresh falling edge; IDLE SHALL wait for one high sample.

Configuration
REQ-035 Macro UART_RX_PARITY_EN defined: STATE PARITY inserted between DATA and STOP; one even-parity bit sampled; output parity_err (sticky, cleared by err_clr) added; a mismatching byte SHALL be discarded and parity_err set.
REQ-036 Macro undefined: no PARITY state and no parity_err port; frames are 8N1.

Structure
REQ-037 Shared package uart_pkg SHALL hold the state encoding and a CLKS_PER_BIT calculation function, shared with the transmit side.
REQ-038 Sub-module uart_rx (synchronizer, FSM, shift register; outputs an 8-bit byte with a 1-cycle push strobe) SHALL be instantiated together with the existing fifo module.

Verification (CLK_VAL_MHZ=1, BAUD_RATE=125000 -> 8 clks/bit, FIFO_DEPTH=4)
REQ-039 Frame 0xA5 8N1 -> rx_valid rises; rx_data=0xA5; one rx_rd_en pulse -> rx_valid=0.
REQ-040 rx low for 3 clks then high -> nothing pushed, rx_valid stays 0, no flags set.
REQ-041 Frame 0x3C with stop bit low -> frame_err=1, FIFO empty; next valid frame 0x11 received; err_clr clears frame_err.
REQ-042 Five frames 0x01..0x05, no reads -> rx_full=1, overrun=1, reads return 0x01..0x04.
REQ-043 FIFO full, pop in the cycle of push of 0x06 -> no overrun, count stays 4, order preserved.
REQ-044 rst asserted during bit 4 of a frame -> all outputs at reset values, partial byte never appears.
